seq_adder32: RTL and testbench
==============================

// Module: seq_adder32
// PURPOSE
//  Multi-cycle chunked two's-complement adder: A+B computed CHUNK bits/cycle,
//  carry rippled through a register between cycles. Counterpart of the
//  combinational subtractor path (recovers A from A-B and B). Sits between
//  datapath stages that tolerate latency in exchange for a short carry chain.
//  valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH  32  operand/result width; must be a multiple of CHUNK
//  CHUNK   8  bits added per cycle; N = WIDTH/CHUNK cycles per operation
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands A,B valid
//  in_ready   out  1      block can accept operands
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  op_sub     in   1      only with ADDSUB_OP_EN: 1 = A-B, 0 = A+B
//  out_valid  out  1      S/C31/OVF valid
//  out_ready  in   1      consumer takes result
//  S          out  WIDTH  sum (mod 2^WIDTH)
//  C31        out  1      carry out of MSB
//  OVF        out  1      signed overflow
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, S=0,
//    C31=0, OVF=0, chunk counter=0, carry reg=0. Reset mid-op aborts it; no output.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. in_valid&in_ready at edge t0: latch A, B_eff (=B, or ~B
//    with op_sub), carry=0 (1 with op_sub), cnt=0, go RUN.
//  - RUN: in_ready=0. Each edge: {c,S[cnt*CHUNK+:CHUNK]} = A_chunk+B_eff_chunk+carry;
//    carry<=c; cnt<=cnt+1. At cnt==N-1 also set C31=c,
//    OVF=(A[MSB]==B_eff[MSB])&&(sum MSB!=A[MSB]); go DONE.
//  - DONE: out_valid=1, S/C31/OVF stable until out_valid&out_ready; on that
//    edge go IDLE, out_valid=0 (S/C31/OVF hold last value).
//  - Latency: out_valid high after edge t0+N (N=4 default); out_ready held
//    high -> one result per N+2 cycles. in_valid ignored outside IDLE.
//  - Carry wraps out of MSB into C31 only; no saturation. CHUNK==WIDTH -> N=1.
//  - A/B/op_sub only sampled at accept; changes later have no effect.
// CONFIGURATION
//  ADDSUB_OP_EN defined: op_sub port present; op_sub=1 computes A+~B+1 (A-B),
//    C31 = no-borrow flag (1 when A>=B unsigned), OVF per signed subtraction.
//  ADDSUB_OP_EN undefined: op_sub port absent; always A+B, initial carry 0.
// TESTING
//  1. Reset asserted mid-RUN -> out_valid=0, in_ready=1 at once, no result.
//  2. A=0x0000_0001,B=0x0000_0002 -> S=0x0000_0003,C31=0,OVF=0, out_valid 4 edges after accept.
//  3. A=0xFFFF_FFFF,B=0x0000_0001 -> S=0,C31=1,OVF=0 (carry through all chunks).
//  4. A=0x7FFF_FFFF,B=0x0000_0001 -> S=0x8000_0000,C31=0,OVF=1.
//  5. out_ready=0 for 10 cycles in DONE -> S/out_valid stable, in_ready=0,
//     extra in_valid ignored; out_ready=1 -> IDLE next edge.
//  6. ADDSUB_OP_EN: A=5,B=7,op_sub=1 -> S=0xFFFF_FFFE,C31=0,OVF=0;
//     A=0x8000_0000,B=1,op_sub=1 -> S=0x7FFF_FFFF,C31=1,OVF=1.

Source files
------------

// File: rtl/seq_adder32.sv
// Multi-cycle chunked adder: CHUNK bits per cycle, carry held in a register.
// Optional subtract mode via ADDSUB_OP_EN (adds op_sub port).
module seq_adder32 #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef ADDSUB_OP_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C31,
  output logic             OVF
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [N-1:0][CHUNK-1:0] a_q;
  logic [N-1:0][CHUNK-1:0] b_q;
  logic [N-1:0][CHUNK-1:0] s_q;
  logic [CW-1:0]           cnt;
  logic                    carry;
  logic [CHUNK:0]          sum;
  logic [WIDTH-1:0]        b_in;
  logic                    cin0;
  logic                    accept;
  logic                    last;

`ifdef ADDSUB_OP_EN
  assign b_in = op_sub ? ~B : B;
  assign cin0 = op_sub;
`else
  assign b_in = B;
  assign cin0 = 1'b0;
`endif

  assign accept = in_valid && (state == IDLE);
  assign last   = (cnt == CW'(N - 1));
  assign sum    = {1'b0, a_q[cnt]} + {1'b0, b_q[cnt]}
                + {{CHUNK{1'b0}}, carry};
  assign S      = s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      (state == RUN): begin
        if (last) state_nx = DONE;
      end
      (state == DONE): begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      C31   <= 1'b0;
      OVF   <= 1'b0;
    end else if (accept) begin
      a_q   <= A;
      b_q   <= b_in;
      carry <= cin0;
      cnt   <= '0;
    end else if (state == RUN) begin
      s_q[cnt] <= sum[CHUNK-1:0];
      carry    <= sum[CHUNK];
      cnt      <= cnt + 1'b1;
      if (last) begin
        C31 <= sum[CHUNK];
        // signed overflow: like-signed operands, result sign differs
        OVF <= (a_q[N-1][CHUNK-1] == b_q[N-1][CHUNK-1])
            && (sum[CHUNK-1] != a_q[N-1][CHUNK-1]);
      end
    end
  end

endmodule

// File: tb/tb_seq_adder32.sv
// Directed-vector bench for seq_adder32.
// Covers reset, latency, carry chains, overflow, stall and abort.
module tb_seq_adder32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
`ifdef ADDSUB_OP_EN
  logic        op_sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [31:0] S;
  logic        C31;
  logic        OVF;

  int ncmp = 0;
  int nbad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        o;
  } vec_t;

  vec_t tv[$];

  seq_adder32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
`ifdef ADDSUB_OP_EN
    .op_sub   (op_sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .S        (S),
    .C31      (C31),
    .OVF      (OVF)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b,
                       input logic sub);
    chk("accept_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    A = a;
    B = b;
`ifdef ADDSUB_OP_EN
    op_sub = sub;
`endif
    tick();
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
`ifdef ADDSUB_OP_EN
    op_sub = ~sub;
`endif
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!out_valid && k < 12) begin
      tick();
      k++;
    end
  endtask

  initial begin
    int k;
    logic seen;
    logic [31:0] hold;

    tv.push_back('{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0});
    tv.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
    tv.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
    tv.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1});
    tv.push_back('{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0});
    tv.push_back('{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0});
    tv.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0});
    tv.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0});
`ifdef ADDSUB_OP_EN
    tv.push_back('{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0});
    tv.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1});
    tv.push_back('{32'h0000_0009, 32'h0000_0009, 1'b1, 32'h0000_0000, 1'b1, 1'b0});
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
`ifdef ADDSUB_OP_EN
    op_sub    = 1'b0;
`endif
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_S", S, 32'd0);
    chk("rst_C31", 32'(C31), 32'd0);
    chk("rst_OVF", 32'(OVF), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (tv[i]) begin
      start(tv[i].a, tv[i].b, tv[i].sub);
      wait_done(k);
      chk($sformatf("v%0d_latency", i), 32'(k), 32'd4);
      chk($sformatf("v%0d_S", i), S, tv[i].s);
      chk($sformatf("v%0d_C31", i), 32'(C31), 32'(tv[i].c));
      chk($sformatf("v%0d_OVF", i), 32'(OVF), 32'(tv[i].o));
      tick();
      chk($sformatf("v%0d_drop", i), 32'(out_valid), 32'd0);
      chk($sformatf("v%0d_hold", i), S, tv[i].s);
    end

    // Stall in DONE with extra in_valid that must be ignored
    out_ready = 1'b0;
    start(32'h0000_0010, 32'h0000_0020, 1'b0);
    wait_done(k);
    chk("stall_latency", 32'(k), 32'd4);
    hold = S;
    chk("stall_S", hold, 32'h0000_0030);
    in_valid = 1'b1;
    A = 32'hDEAD_BEEF;
    B = 32'h1111_1111;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("stall%0d_S", c), S, 32'h0000_0030);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("stall_release_valid", 32'(out_valid), 32'd0);
    chk("stall_release_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("stall_no_ghost", 32'(seen), 32'd0);

    // Reset in the middle of RUN aborts the operation
    start(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_S", S, 32'd0);
    chk("abort_C31", 32'(C31), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", 32'(seen), 32'd0);

    // Back-to-back throughput: one result per N+2 cycles
    start(32'h0000_0100, 32'h0000_0001, 1'b0);
    wait_done(k);
    chk("b2b0_S", S, 32'h0000_0101);
    tick();
    start(32'h4000_0000, 32'h4000_0000, 1'b0);
    wait_done(k);
    chk("b2b1_latency", 32'(k), 32'd4);
    chk("b2b1_S", S, 32'h8000_0000);
    chk("b2b1_OVF", 32'(OVF), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
